// File: rtl/pwm_duty_decoder.sv
// Recovers a PWM brightness code by counting high samples and rising edges
// over free-running windows of 2^CNT_WIDTH cycles.
module pwm_duty_decoder #(
    parameter int CNT_WIDTH   = 10,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 pwm_in,
    output logic [CNT_WIDTH-1:0] duty,
    output logic [CNT_WIDTH-1:0] edges,
    output logic                 duty_valid,
    output logic                 changed,
    output logic                 stuck_high,
    output logic                 stuck_low
);

    localparam logic [CNT_WIDTH:0] FULL_WINDOW = {1'b1, {CNT_WIDTH{1'b0}}};

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   s_prev_reg;
    logic [CNT_WIDTH-1:0]   win_ctr_reg;
    logic [CNT_WIDTH:0]     high_acc_reg;
    logic [CNT_WIDTH-1:0]   edge_acc_reg;
    logic [CNT_WIDTH-1:0]   duty_reg;
    logic [CNT_WIDTH-1:0]   edges_reg;
    logic                   duty_valid_reg;
    logic                   changed_reg;
    logic                   stuck_high_reg;
    logic                   stuck_low_reg;

    logic                   s;
    logic                   rise;
    logic                   win_last;
    logic [CNT_WIDTH:0]     high_total;
    logic [CNT_WIDTH-1:0]   edge_total;
    logic [CNT_WIDTH-1:0]   duty_next;

    assign s          = sync_reg[SYNC_STAGES-1];
    assign rise       = s & ~s_prev_reg;
    assign win_last   = (win_ctr_reg == {CNT_WIDTH{1'b1}});
    // Include the current sample so the closing cycle is counted in this window.
    assign high_total = high_acc_reg + {{CNT_WIDTH{1'b0}}, s};
    assign edge_total = edge_acc_reg + {{(CNT_WIDTH-1){1'b0}}, rise};
    // A fully-high window needs one more bit than duty has; clamp it.
    assign duty_next  = high_total[CNT_WIDTH] ? {CNT_WIDTH{1'b1}} : high_total[CNT_WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_reg       <= '0;
            s_prev_reg     <= 1'b0;
            win_ctr_reg    <= '0;
            high_acc_reg   <= '0;
            edge_acc_reg   <= '0;
            duty_reg       <= '0;
            edges_reg      <= '0;
            duty_valid_reg <= 1'b0;
            changed_reg    <= 1'b0;
            stuck_high_reg <= 1'b0;
            stuck_low_reg  <= 1'b0;
        end else begin
            sync_reg    <= {sync_reg[SYNC_STAGES-2:0], pwm_in};
            s_prev_reg  <= s;
            win_ctr_reg <= win_ctr_reg + CNT_WIDTH'(1);
            if (win_last) begin
                duty_reg       <= duty_next;
                edges_reg      <= edge_total;
                stuck_high_reg <= (high_total == FULL_WINDOW);
                stuck_low_reg  <= (high_total == '0);
                changed_reg    <= (duty_next != duty_reg);
                duty_valid_reg <= 1'b1;
                high_acc_reg   <= '0;
                edge_acc_reg   <= '0;
            end else begin
                high_acc_reg   <= high_total;
                edge_acc_reg   <= edge_total;
                duty_valid_reg <= 1'b0;
                changed_reg    <= 1'b0;
            end
        end
    end

    assign duty       = duty_reg;
    assign edges      = edges_reg;
    assign duty_valid = duty_valid_reg;
    assign changed    = changed_reg;
    assign stuck_high = stuck_high_reg;
    assign stuck_low  = stuck_low_reg;

endmodule
